fir_serial_sequencer: RTL and testbench

- Time-multiplexed FIR controller: one shared multiplier-accumulator sequenced over TAPS coefficients per input sample.
- Replaces the fully parallel 9-multiplier FIR where area matters.
- Holds a programmable coefficient bank and a circular sample delay line.
- Sits between the sample source and sink; both sides use valid/ready handshakes.

---
 rtl/fir_pkg.sv | 24 ++
 rtl/fir_delay_line.sv | 42 ++++
 rtl/fir_serial_sequencer.sv | 125 ++++++++++++
 tb/tb_fir_serial_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the serial FIR sequencer: tap limits, default
// coefficient bank, accumulator sizing and controller states.
package fir_pkg;

  localparam int TAPS_MAX = 16;
  localparam int IDX_W    = 4;

  // Symmetric low-pass default; entries past the ninth tap are zero.
  localparam int unsigned DEF_COEF [TAPS_MAX] = '{
    0, 7, 61, 33, 68, 33, 61, 7, 0, 0, 0, 0, 0, 0, 0, 0
  };

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  // Four guard bits cover the sum of up to 16 full-scale products.
  function automatic int acc_width(input int n, input int cw);
    return n + cw + 4;
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Circular sample store: each push advances the head and writes the new
// sample there; reads address samples at an age offset behind the head.
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int N    = 16,
  parameter int TAPS = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [N-1:0]         push_data,
  input  logic [IDX_W-1:0]     offset,
  output logic [N-1:0]         rd_data
);

  logic [N-1:0]     line [TAPS];
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] head_next;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W:0]   wrap_idx;

  assign head_next = (head == IDX_W'(TAPS - 1)) ? '0 : head + 1'b1;

  // Offsets past the head wrap back around the top of the ring.
  assign wrap_idx = {1'b0, head} + (IDX_W + 1)'(TAPS) - {1'b0, offset};
  assign rd_idx   = (head >= offset) ? head - offset : wrap_idx[IDX_W-1:0];
  assign rd_data  = line[rd_idx];

  always_ff @(posedge clk) begin
    if (!reset) begin
      head <= '0;
      for (int i = 0; i < TAPS; i++) begin
        line[i] <= '0;
      end
    end else if (push) begin
      head            <= head_next;
      line[head_next] <= push_data;
    end
  end

endmodule

// File: rtl/fir_serial_sequencer.sv
// Time-multiplexed FIR: one multiply-accumulate per cycle over TAPS taps.
// Build option FIR_OUT_SAT_EN saturates the output instead of wrapping.
module fir_serial_sequencer
  import fir_pkg::*;
#(
  parameter int N         = 16,
  parameter int CW        = 11,
  parameter int TAPS      = 9,
  parameter int OUT_SHIFT = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  data_out,
  input  logic          coef_we,
  input  logic [3:0]    coef_addr,
  input  logic [CW-1:0] coef_wdata,
  output logic          coef_err,
  output logic          busy
);

  localparam int AW = acc_width(N, CW);
  localparam int PW = N + CW;
  localparam logic [IDX_W-1:0] LAST_K = IDX_W'(TAPS - 1);

  state_t           state;
  logic [IDX_W-1:0] k;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    acc_next;
  logic [CW-1:0]    coef [TAPS];
  logic [N-1:0]     x_k;
  logic [PW-1:0]    prod;
  logic             accept;
  logic             coef_ok;

  function automatic logic [N-1:0] shape_out(input logic [AW-1:0] a);
    logic [AW-1:0] s;
    s = a >> OUT_SHIFT;
`ifdef FIR_OUT_SAT_EN
    if (|s[AW-1:N]) begin
      return '1;
    end
`endif
    return s[N-1:0];
  endfunction

  assign accept  = (state == IDLE) && in_valid && in_ready;
  assign coef_ok = (state == IDLE) && ({1'b0, coef_addr} < (IDX_W + 1)'(TAPS));

  fir_delay_line #(
    .N    (N),
    .TAPS (TAPS)
  ) u_line (
    .clk       (clk),
    .reset     (reset),
    .push      (accept),
    .push_data (in_data),
    .offset    (k),
    .rd_data   (x_k)
  );

  assign prod     = PW'(x_k) * PW'(coef[k]);
  assign acc_next = acc + AW'(prod);

  // A coefficient write and a sample accept in the same cycle both commit at
  // that edge, so the sample's MAC pass already sees the new coefficient.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      data_out  <= '0;
      coef_err  <= 1'b0;
      busy      <= 1'b0;
      acc       <= '0;
      k         <= '0;
      for (int i = 0; i < TAPS; i++) begin
        coef[i] <= CW'(DEF_COEF[i]);
      end
    end else begin
      coef_err <= coef_we && !coef_ok;
      if (coef_we && coef_ok) begin
        coef[coef_addr] <= coef_wdata;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            busy     <= 1'b1;
            acc      <= '0;
            k        <= '0;
            state    <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          if (k == LAST_K) begin
            data_out  <= shape_out(acc_next);
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            k <= k + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_serial_sequencer.sv
// Directed bench for fir_serial_sequencer with a shift-register reference
// model; honours FIR_OUT_SAT_EN the same way as the design.
module tb_fir_serial_sequencer;

  localparam int N         = 16;
  localparam int CW        = 11;
  localparam int TAPS      = 9;
  localparam int OUT_SHIFT = 0;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N-1:0]  data_out;
  logic          coef_we = 1'b0;
  logic [3:0]    coef_addr = '0;
  logic [CW-1:0] coef_wdata = '0;
  logic          coef_err;
  logic          busy;

  always #5 clk = ~clk;

  fir_serial_sequencer #(
    .N (N), .CW (CW), .TAPS (TAPS), .OUT_SHIFT (OUT_SHIFT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .coef_err   (coef_err),
    .busy       (busy)
  );

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  longint unsigned hist [TAPS];
  longint unsigned mcoef [TAPS];
  logic [N-1:0]    exp_q [$];
  int unsigned     acc_q [$];
  logic [N-1:0]    got_q [$];
  logic            prev_valid = 1'b0;
  int unsigned     last_accept = 0;
  logic [N-1:0]    dummy_d;
  int unsigned     dummy_c;

  int imp_lit  [$] = '{0, 7, 61, 33, 68, 33, 61, 7, 0, 0};
  int step_lit [$] = '{0, 7, 68, 101, 169, 202, 263, 270, 270, 270, 270, 270};
  int cimp_lit [$] = '{0, 7, 61, 33, 1, 33, 61, 7, 0};
  int def_lit  [$] = '{0, 7, 61, 33, 68, 33, 61, 7, 0};

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    acc_q.delete();
    for (int i = 0; i < TAPS; i++) begin
      hist[i]  = 0;
      mcoef[i] = longint'(def_lit[i]);
    end
  endtask

  // Newest sample sits at hist[0]; output is the plain dot product.
  task automatic model_accept(input logic [N-1:0] x);
    longint unsigned a;
    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = longint'(x);
    a = 0;
    for (int i = 0; i < TAPS; i++) a += hist[i] * mcoef[i];
    a = a >> OUT_SHIFT;
`ifdef FIR_OUT_SAT_EN
    if (a > 64'(2**N - 1)) a = 64'(2**N - 1);
`endif
    exp_q.push_back(N'(a));
    acc_q.push_back(cyc + 1);
  endtask

  always @(negedge clk) begin
    if (reset && out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 1, 0);
      end else begin
        if (!prev_valid) check("latency", longint'(cyc - acc_q[0]), TAPS);
        check("data_out", data_out, exp_q[0]);
        check("in_ready_low_in_out", in_ready, 0);
        if (out_ready) begin
          got_q.push_back(data_out);
          dummy_d = exp_q.pop_front();
          dummy_c = acc_q.pop_front();
        end
      end
    end
    prev_valid = reset && out_valid && !out_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [N-1:0] x);
    in_valid = 1'b1;
    in_data  = x;
  endtask

  task automatic wait_accept();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", in_ready, 1);
    if (in_ready) begin
      last_accept = cyc + 1;
      model_accept(in_data);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [N-1:0] x);
    present(x);
    wait_accept();
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      tick();
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic check_got(input string name, input int lits[$]);
    check({name, "_count"}, got_q.size(), lits.size());
    for (int i = 0; i < lits.size() && i < got_q.size(); i++) begin
      check(name, got_q[i], lits[i]);
    end
  endtask

  task automatic coef_write(input logic [3:0] a, input logic [CW-1:0] d, input logic err);
    coef_addr  = a;
    coef_wdata = d;
    coef_we    = 1'b1;
    tick();
    coef_we = 1'b0;
    check("coef_err_pulse", coef_err, err);
    if (!err) mcoef[a] = longint'(d);
    tick();
    check("coef_err_clear", coef_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int unsigned prev_acc;
    logic [N-1:0] held;
    int n;

    model_reset();
    repeat (3) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_coef_err", coef_err, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    tick();

    // Impulse response reproduces the coefficient bank.
    got_q.delete();
    send(1);
    repeat (9) send(0);
    drain();
    check_got("impulse", imp_lit);

    // Step response with back-to-back accepts at the minimum period.
    got_q.delete();
    send(1);
    prev_acc = last_accept;
    for (int i = 1; i < 12; i++) begin
      send(1);
      check("min_period", longint'(last_accept - prev_acc), TAPS + 2);
      prev_acc = last_accept;
    end
    drain();
    check_got("step", step_lit);

    // Backpressure: result held, new sample waits for the handshake.
    out_ready = 1'b0;
    send(5);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    check("bp_valid_seen", out_valid, 1);
    held = data_out;
    present(9);
    repeat (5) begin
      tick();
      check("bp_stable", data_out, held);
      check("bp_in_ready", in_ready, 0);
      check("bp_busy", busy, 1);
    end
    out_ready = 1'b1;
    wait_accept();
    drain();

    // Coefficient programming and dropped writes.
    coef_write(4, 1, 1'b0);
    coef_write(12, 99, 1'b1);
    send(3);
    coef_write(2, 500, 1'b1);
    drain();
    repeat (9) send(0);
    drain();
    got_q.delete();
    send(1);
    repeat (8) send(0);
    drain();
    check_got("coef_impulse", cimp_lit);

    // Reset in the middle of a MAC pass discards the result.
    send(1);
    tick();
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_valid", out_valid, 0);
    reset = 1'b1;
    repeat (TAPS + 4) begin
      tick();
      check("midrst_no_valid", out_valid, 0);
    end
    got_q.delete();
    send(1);
    repeat (9) send(0);
    drain();
    check_got("reset_impulse", imp_lit);

    // Full-scale input exceeds the N-bit output range.
    got_q.delete();
    repeat (9) send(16'hFFFF);
    drain();
    check("ovf_count", got_q.size(), 9);
    if (got_q.size() == 9) begin
`ifdef FIR_OUT_SAT_EN
      check("overflow_out", got_q[8], 16'hFFFF);
`else
      check("overflow_out", got_q[8], 16'hFEF2);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
